load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-side executor for the Load/Store/fun3 controls produced in decode. It sits in the MEM stage of the 5-stage RV32I pipeline. It accepts one load or store per handshake and formats byte lanes and write masks. It drives a request/grant/rvalid data-memory port and returns sign- or zero-extended load data. While an access is in flight it stalls the pipeline.

Parameters:
ADDR_W, 32, byte-address width of the data-memory port
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  MEM stage presents an access
req_ready  out  1  unit can accept an access
load  in  1  access is a load
store  in  1  access is a store
fun3  in  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu, 110 treated as w
addr  in  ADDR_W  effective byte address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  pipeline hold while busy
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address, low 2 bits = 0
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte write enables
mem_gnt  in  1  memory accepted mem_req this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores
rsp_err  out  1  misaligned access; exists only with MISALIGN_TRAP_EN

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except req_ready=1. rsp_rdata=0.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE: req_ready=1, stall=0.
  - Accept when req_valid && (load||store): latch fun3, addr, formatted wdata and mask, then go to REQ.
  - If load and store are both 1, store wins.
  - req_valid with neither set produces no action and no response.
- REQ: mem_req=1. mem_we, mem_addr, mem_wdata and mem_wmask stay stable until mem_gnt.
  - Store + gnt: go to RESP.
  - Load + gnt: go to WAIT_R.
  - mem_wmask=0 for loads.
- WAIT_R: mem_req=0. mem_rvalid is honoured only in this state, earliest one cycle after gnt. On rvalid, latch extended data and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0.
- stall = (state != IDLE) || (req_valid && req_ready && (load||store)).
- Minimum latency, accept to rsp_valid: store 2 cycles (gnt in first REQ cycle); load 3 cycles.
- Store formatting:
  - sb: byte replicated to all 4 lanes, mask = 4'b0001 << addr[1:0].
  - sh: halfword replicated, mask = 4'b0011 << {addr[1],1'b0}.
  - sw: mask 4'b1111.
- Load extraction:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw/110 pass the full word.
- Misalignment (no macro): low bits are silently ignored. h uses addr[1] only; w ignores addr[1:0].
- Reset mid-operation: mem_req drops asynchronously and the FSM returns to IDLE. Any rvalid arriving after reset is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: the rsp_err port exists. An accepted h with addr[0]=1, or w with addr[1:0]!=0, skips REQ/WAIT_R with no mem_req. It goes directly to RESP with rsp_err=1 and rsp_rdata=0. rsp_err is 0 on all other responses.
- Undefined: the port is absent and misalignment is handled as above.

Decomposition:
- Shared package lsu_pkg holds:
  - fun3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU, F3_WU);
  - FSM state encoding (2-bit);
  - mask constants.
- One combinational sub-module, lsu_align, does store lane replication/mask generation and load lane select/extension. The FSM lives in load_store_unit.

Test Plan:
1. sb: wdata=0x000000A5, addr=0x1003, gnt immediate -> mem_wdata=0xA5A5A5A5, mem_wmask=4'b1000, mem_addr=0x1000; rsp_valid 2 cycles after accept, rsp_rdata=0.
2. lb: addr=0x2001, mem_rdata=0x1234F678, rvalid one cycle after gnt -> rsp_rdata=0xFFFFFFF6. Repeat as lbu -> 0x000000F6.
3. lh: addr=0x2002, mem_rdata=0x8001ABCD -> rsp_rdata=0xFFFF8001. Repeat as lhu -> 0x00008001.
4. sw: gnt held low for 3 cycles -> mem_req and all mem_* stable for 4 cycles; stall=1 throughout; single rsp_valid pulse.
5. Reset pulse while in WAIT_R, then rvalid=1 -> no rsp_valid, req_ready=1, mem_req=0 immediately.
6. MISALIGN_TRAP_EN defined, lw at addr=0x3002 -> no mem_req; rsp_valid and rsp_err=1 one cycle after accept. Without the macro -> mem_addr=0x3000 and a normal load.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: fun3 size codes, FSM state
// encoding, byte-mask constants and a small fun3 decode helper.
package lsu_pkg;

  // fun3 size/sign codes as produced by decode
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // FSM state encoding (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT_R = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Byte write-enable patterns before lane shifting
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Access size from fun3; unlisted codes fall back to a full word
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W, F3_WU: return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  // Byte and halfword loads sign-extend unless fun3[2] selects unsigned
  function automatic logic f3_signed(input logic [2:0] f3);
    return ~f3[2];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
// Store side: replicates byte/halfword data across lanes and builds the
// write mask. Load side: selects the addressed lane and sign/zero-extends.
// Misaligned low address bits are simply dropped: halfwords look only at
// addr[1], words ignore addr[1:0].
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        st_fun3,
  input  logic [1:0]        st_addr_lo,
  input  logic [DATA_W-1:0] st_wdata,
  output logic [DATA_W-1:0] st_wdata_fmt,
  output logic [3:0]        st_wmask,
  input  logic [2:0]        ld_fun3,
  input  logic [1:0]        ld_addr_lo,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_rdata_ext
);

  // Byte to word, signed or unsigned
  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]        bs;
    logic signed [DATA_W-1:0] r;
    bs = b;
    r  = bs;
    if (sgn) return r;
    return {{(DATA_W-8){1'b0}}, b};
  endfunction

  // Halfword to word, signed or unsigned
  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0]       hs;
    logic signed [DATA_W-1:0] r;
    hs = h;
    r  = hs;
    if (sgn) return r;
    return {{(DATA_W-16){1'b0}}, h};
  endfunction

  lsu_size_e  st_size;
  lsu_size_e  ld_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign st_size = f3_size(st_fun3);
  assign ld_size = f3_size(ld_fun3);

  // Store lane replication and byte-enable generation
  always_comb begin
    st_wdata_fmt = st_wdata;
    st_wmask     = MASK_W;
    case (st_size)
      SZ_B: begin
        st_wdata_fmt = {4{st_wdata[7:0]}};
        st_wmask     = MASK_B << st_addr_lo;
      end
      SZ_H: begin
        st_wdata_fmt = {2{st_wdata[15:0]}};
        st_wmask     = MASK_H << {st_addr_lo[1], 1'b0};
      end
      default: begin
        st_wdata_fmt = st_wdata;
        st_wmask     = MASK_W;
      end
    endcase
  end

  // Load lane selection
  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_addr_lo)
      2'd0: ld_byte = ld_rdata[7:0];
      2'd1: ld_byte = ld_rdata[15:8];
      2'd2: ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
  end

  // Load extension by access size
  always_comb begin
    ld_rdata_ext = ld_rdata;
    case (ld_size)
      SZ_B:    ld_rdata_ext = ext_byte(ld_byte, f3_signed(ld_fun3));
      SZ_H:    ld_rdata_ext = ext_half(ld_half, f3_signed(ld_fun3));
      default: ld_rdata_ext = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store executor for the RV32I pipeline.
// Accepts one load or store per handshake, drives a req/gnt/rvalid data
// memory port and returns extended load data with a one-cycle rsp_valid.
// The pipeline is stalled from the accept cycle until the response.
// Optional build macro MISALIGN_TRAP_EN: adds rsp_err; misaligned halfword
// or word accesses skip the memory and respond immediately with rsp_err=1.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              load,
  input  logic              store,
  input  logic [2:0]        fun3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
`ifdef MISALIGN_TRAP_EN
  output logic              rsp_err,
`endif
  output logic [DATA_W-1:0] rsp_rdata
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              accept;
  logic              misalign;

  // Captured request (p0) and captured load result (p1)
  logic              we_p0;
  logic [2:0]        fun3_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [3:0]        wmask_p0;
  logic [DATA_W-1:0] rdata_p1;

  logic [DATA_W-1:0] st_wdata_fmt;
  logic [3:0]        st_wmask;
  logic [DATA_W-1:0] ld_rdata_ext;

  // Store formatting runs on the live request; load extension on the
  // captured fun3/address against the returning memory word.
  lsu_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .st_fun3      (fun3),
    .st_addr_lo   (addr[1:0]),
    .st_wdata     (wdata),
    .st_wdata_fmt (st_wdata_fmt),
    .st_wmask     (st_wmask),
    .ld_fun3      (fun3_p0),
    .ld_addr_lo   (addr_p0[1:0]),
    .ld_rdata     (mem_rdata),
    .ld_rdata_ext (ld_rdata_ext)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready && (load || store);
  assign stall     = (state_q != ST_IDLE) || accept;

`ifdef MISALIGN_TRAP_EN
  lsu_size_e req_size;
  logic      err_q;

  assign req_size = f3_size(fun3);
  assign misalign = ((req_size == SZ_H) && addr[0]) ||
                    ((req_size == SZ_W) && (addr[1:0] != 2'b00));

  // Error flag for the response belonging to the accepted access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end

  assign rsp_err = rsp_valid && err_q;
`else
  assign misalign = 1'b0;
`endif

  // Next-state logic; store wins when load and store are both set
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = misalign ? ST_RESP : ST_REQ;
      end
      ST_REQ: begin
        if (mem_gnt) state_d = we_p0 ? ST_RESP : ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (mem_rvalid) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; async reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- stage p0: request capture on accept ----
  // Request capture; held stable through REQ until grant
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= store;
      fun3_p0  <= fun3;
      addr_p0  <= addr;
      wdata_p0 <= st_wdata_fmt;
      wmask_p0 <= store ? st_wmask : MASK_NONE;
    end
  end

  // ---- stage p1: response data capture ----
  // Cleared on accept so stores and trapped accesses return zero
  always_ff @(posedge clk) begin
    if (accept) begin
      rdata_p1 <= '0;
    end else if ((state_q == ST_WAIT_R) && mem_rvalid) begin
      rdata_p1 <= ld_rdata_ext;
    end
  end

  // Memory port is driven only while requesting, zero otherwise
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req && we_p0;
  assign mem_addr  = mem_req ? {addr_p0[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? wdata_p0 : '0;
  assign mem_wmask = mem_req ? wmask_p0 : MASK_NONE;

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_p1 : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// loads/stores with random grant and rvalid delays, checked every cycle
// against a transaction-level model. Honours MISALIGN_TRAP_EN if defined.
module tb_load_store_unit;

  localparam int ADDR_W = 32;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid, req_ready, load, store;
  logic [2:0]  fun3;
  logic [31:0] addr, wdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
`ifdef MISALIGN_TRAP_EN
  logic        rsp_err;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .load(load), .store(store), .fun3(fun3), .addr(addr), .wdata(wdata),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid),
`ifdef MISALIGN_TRAP_EN
    .rsp_err(rsp_err),
`endif
    .rsp_rdata(rsp_rdata)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int mreq_cnt = 0;

  // Expected outputs for the current cycle
  bit          e_ready, e_stall, e_mreq, e_we, e_wd_chk, e_rsp, e_err;
  logic [31:0] e_addr, e_wd, e_rdata;
  logic [3:0]  e_mask;

  // Last observed DUT values, for literal checks after directed cases
  logic [31:0] last_maddr, last_mwd, last_rdata;
  logic [3:0]  last_mmask;
  bit          last_err;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what the memory port and response must carry for one access
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic [31:0] ea, output logic [31:0] ewd,
                                output logic [3:0] emask, output logic [31:0] erd,
                                output bit trap);
    int     size, lo, off;
    longint v, span;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lo   = int'(a & 32'd3);
    off  = (size == 1) ? lo : (size == 2) ? ((lo >= 2) ? 2 : 0) : 0;
    trap = TRAP && ((lo % size) != 0);
    ea   = a & 32'hFFFF_FFFC;
    for (int i = 0; i < 4; i++) begin
      emask[i]      = st && (i >= off) && (i < off + size);
      ewd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    span = longint'(1) << (8 * size);
    v    = longint'(rd >> (8 * off));
    if (size < 4) begin
      v = v % span;
      if (!f3[2] && (v >= span / 2)) v = v - span;
    end
    erd = (st || trap) ? 32'd0 : v[31:0];
  endfunction

  // Per-cycle comparison against the expectations set by the driver
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("req_ready", req_ready, e_ready);
      chk1("stall", stall, e_stall);
      chk1("mem_req", mem_req, e_mreq);
      chk1("rsp_valid", rsp_valid, e_rsp);
      if (mem_req) mreq_cnt++;
      if (e_mreq) begin
        chk1("mem_we", mem_we, e_we);
        chk32("mem_addr", mem_addr, e_addr);
        chk32("mem_wmask", {28'd0, mem_wmask}, {28'd0, e_mask});
        if (e_wd_chk) chk32("mem_wdata", mem_wdata, e_wd);
        last_maddr = mem_addr;
        last_mwd   = mem_wdata;
        last_mmask = mem_wmask;
      end
      if (e_rsp) begin
        chk32("rsp_rdata", rsp_rdata, e_rdata);
        last_rdata = rsp_rdata;
`ifdef MISALIGN_TRAP_EN
        chk1("rsp_err", rsp_err, e_err);
        last_err = rsp_err;
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit rdy, input bit stl, input bit mreq, input bit rsp);
    e_ready = rdy; e_stall = stl; e_mreq = mreq; e_rsp = rsp;
  endtask

  // Random request-side noise while the unit is busy (must be ignored)
  task automatic scramble();
    req_valid = 1'($urandom_range(0, 1));
    load      = 1'($urandom_range(0, 1));
    store     = 1'($urandom_range(0, 1));
    fun3      = 3'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
  endtask

  task automatic idle_cycle();
    req_valid  = 1'($urandom_range(0, 1));
    load = 1'b0; store = 1'b0;
    fun3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  // One access with gd cycles of grant delay and rvd cycles of rvalid delay
  task automatic do_txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rvd);
    logic [31:0] ea, ewd, erd;
    logic [3:0]  emask;
    bit          trap;
    model(st, f3, a, wd, rd, ea, ewd, emask, erd, trap);
    req_valid = 1'b1; load = ld; store = st; fun3 = f3; addr = a; wdata = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    if (!trap) begin
      for (int k = 0; k <= gd; k++) begin
        scramble();
        mem_gnt = (k == gd);
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        set_exp(1'b0, 1'b1, 1'b1, 1'b0);
        e_we = st; e_addr = ea; e_wd = ewd; e_wd_chk = st; e_mask = emask;
        step();
      end
      mem_gnt = 1'b0;
      if (!st) begin
        for (int k = 0; k <= rvd; k++) begin
          scramble();
          mem_rvalid = (k == rvd);
          mem_rdata  = (k == rvd) ? rd : $urandom;
          set_exp(1'b0, 1'b1, 1'b0, 1'b0);
          step();
        end
      end
    end
    scramble();
    mem_gnt = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    set_exp(1'b0, 1'b1, 1'b0, 1'b1);
    e_rdata = erd; e_err = trap;
    step();
  endtask

  task automatic post_reset_checks(input string tag);
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b0; load = 1'b0; store = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = $urandom; mem_gnt = 1'b0;
      @(negedge clk);
      chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk1({tag, "_req_ready"}, req_ready, 1'b1);
      chk1({tag, "_mem_req"}, mem_req, 1'b0);
      @(posedge clk);
      #1;
    end
    mem_rvalid = 1'b0;
  endtask

  logic [2:0] ld_f3s [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

  initial begin
    int m0;
    req_valid = 1'b0; load = 1'b0; store = 1'b0; fun3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #1 rst_n = 1'b0;
    #2;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk32("rst_mem_wdata", mem_wdata, 32'd0);
    chk32("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk1("rst_rsp_err", rsp_err, 1'b0);
`endif
    step();
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle_cycle();

    // sb at byte 3
    do_txn(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'd0, 0, 0);
    chk32("sb_wdata", last_mwd, 32'hA5A5_A5A5);
    chk32("sb_wmask", {28'd0, last_mmask}, 32'h8);
    chk32("sb_addr", last_maddr, 32'h0000_1000);
    chk32("sb_rdata", last_rdata, 32'd0);
    // lb / lbu at byte 1
    do_txn(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'd0, 32'h1234_F678, 0, 0);
    chk32("lb_rdata", last_rdata, 32'hFFFF_FFF6);
    do_txn(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'd0, 32'h1234_F678, 0, 0);
    chk32("lbu_rdata", last_rdata, 32'h0000_00F6);
    // lh / lhu at upper half
    do_txn(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'h8001_ABCD, 0, 0);
    chk32("lh_rdata", last_rdata, 32'hFFFF_8001);
    do_txn(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'h8001_ABCD, 0, 0);
    chk32("lhu_rdata", last_rdata, 32'h0000_8001);
    // sh at upper half, both load and store set -> store
    do_txn(1'b1, 1'b1, 3'b001, 32'h0000_4002, 32'h1234_BEEF, 32'd0, 1, 0);
    chk32("sh_wmask", {28'd0, last_mmask}, 32'hC);
    chk32("sh_wdata", last_mwd, 32'hBEEF_BEEF);
    // sw with grant held off for three cycles
    m0 = mreq_cnt;
    do_txn(1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'hDEAD_BEEF, 32'd0, 3, 0);
    chk32("sw_mreq_cycles", 32'(mreq_cnt - m0), 32'd4);
    chk32("sw_wmask", {28'd0, last_mmask}, 32'hF);
    // lw at a misaligned address
    m0 = mreq_cnt;
    do_txn(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'd0, 32'hCAFE_F00D, 0, 1);
`ifdef MISALIGN_TRAP_EN
    chk32("lw_mis_mreq_cycles", 32'(mreq_cnt - m0), 32'd0);
    chk1("lw_mis_err", last_err, 1'b1);
    chk32("lw_mis_rdata", last_rdata, 32'd0);
`else
    chk32("lw_mis_addr", last_maddr, 32'h0000_3000);
    chk32("lw_mis_rdata", last_rdata, 32'hCAFE_F00D);
`endif

    // Reset while waiting for read data; late rvalid must be ignored
    chk_en = 1'b0;
    req_valid = 1'b1; load = 1'b1; store = 1'b0; fun3 = 3'b010; addr = 32'h0000_6000;
    step();
    req_valid = 1'b0; load = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk1("wait_r_stall", stall, 1'b1);
    chk1("wait_r_mem_req", mem_req, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_wait_req_ready", req_ready, 1'b1);
    chk1("rst_wait_stall", stall, 1'b0);
    step();
    rst_n = 1'b1;
    post_reset_checks("rst_wait");

    // Reset while requesting; mem_req must drop without a clock edge
    req_valid = 1'b1; load = 1'b1; store = 1'b0; fun3 = 3'b010; addr = 32'h0000_7000;
    mem_gnt = 1'b0;
    step();
    req_valid = 1'b0; load = 1'b0;
    @(negedge clk);
    chk1("req_mem_req", mem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_req_mem_req", mem_req, 1'b0);
    chk1("rst_req_req_ready", req_ready, 1'b1);
    step();
    rst_n = 1'b1;
    post_reset_checks("rst_req");

    // Randomized traffic
    chk_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int kind;
      int nidle;
      logic [2:0] f3;
      nidle = $urandom_range(0, 2);
      for (int i = 0; i < nidle; i++) idle_cycle();
      kind = $urandom_range(0, 3);
      if (kind == 1 || kind == 2) begin
        f3 = 3'($urandom_range(0, 2));
        do_txn(kind == 2, 1'b1, f3, $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        f3 = ld_f3s[$urandom_range(0, 5)];
        do_txn(1'b1, 1'b0, f3, $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 2));
      end
    end
    idle_cycle();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
